// File: rtl/branch_resolve_rv32i.sv
// rtl/branch_resolve_rv32i.sv - EX-stage branch/jump resolver with PC redirect and wrong-path flush
module branch_resolve_rv32i #(
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             stall_i,
   input  logic             ex_valid_i,
   input  logic             is_branch_i,
   input  logic             is_jal_i,
   input  logic             is_jalr_i,
   input  logic [2:0]       funct3_i,
   input  logic [31:0]      pc_i,
   input  logic [31:0]      imm_i,
   input  logic [31:0]      rs1_i,
   input  logic             eq_i,
   input  logic             neq_i,
   input  logic             lt_i,
   input  logic             ge_i,
   input  logic             ltu_i,
   input  logic             geu_i,
   output logic             redirect_o,
   output logic [31:0]      target_o,
   output logic [31:0]      link_o,
   output logic             flush_o,
   output logic             misalign_o,
   output logic             illegal_o,
   output logic [CNT_W-1:0] taken_count_o
);

   typedef enum logic {IDLE, FLUSH} state_t;

   state_t      state, state_next;
   logic [3:0]  flush_cnt, flush_cnt_next;

   logic        accept;
   logic        cond_taken;
   logic        cond_illegal;
   logic        taken;
   logic [31:0] jalr_sum;
   logic [31:0] target_calc;
   logic        do_redirect;
   logic        do_misalign;
   logic        do_illegal;

   // Resolve the EX instruction: pick the comparator flag, compute the target, classify the outcome
   always_comb begin
      cond_taken   = 1'b0;
      cond_illegal = 1'b0;
      taken        = 1'b0;
      jalr_sum     = rs1_i + imm_i;
      target_calc  = pc_i + imm_i;
      accept       = ex_valid_i & ~stall_i & (state == IDLE)
                     & (is_jal_i | is_jalr_i | is_branch_i);

      case (funct3_i)
         3'b000:  cond_taken = eq_i;
         3'b001:  cond_taken = neq_i;
         3'b100:  cond_taken = lt_i;
         3'b101:  cond_taken = ge_i;
         3'b110:  cond_taken = ltu_i;
         3'b111:  cond_taken = geu_i;
         default: cond_illegal = 1'b1;
      endcase

      // JAL wins over JALR, which wins over a conditional branch
      if (is_jal_i) begin
         taken = 1'b1;
      end else if (is_jalr_i) begin
         taken       = 1'b1;
         target_calc = {jalr_sum[31:1], 1'b0};
      end else begin
         taken = cond_taken;
      end

      // A target with bit 1 set is reported instead of being fetched
      do_redirect = accept & taken & ~target_calc[1];
      do_misalign = accept & taken & target_calc[1];
      do_illegal  = accept & ~is_jal_i & ~is_jalr_i & cond_illegal;
   end

   // FSM state and flush counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         flush_cnt <= 4'd0;
      end else begin
         state     <= state_next;
         flush_cnt <= flush_cnt_next;
      end
   end

   // Next-state logic: a redirect arms the flush window, which counts down only when not stalled
   always_comb begin
      state_next     = state;
      flush_cnt_next = flush_cnt;
      case (state)
         IDLE: begin
            if (do_redirect) begin
               state_next     = FLUSH;
               flush_cnt_next = 4'(FLUSH_CYCLES);
            end
         end
         FLUSH: begin
            if (!stall_i) begin
               flush_cnt_next = flush_cnt - 4'd1;
               if (flush_cnt == 4'd1) state_next = IDLE;
            end
         end
         default: begin
            state_next     = IDLE;
            flush_cnt_next = 4'd0;
         end
      endcase
   end

   assign flush_o = (state == FLUSH);

   // Registered results: pulses last one cycle, target/link hold until the next accepted transfer
   always_ff @(posedge clk) begin
      if (rst) begin
         redirect_o    <= 1'b0;
         misalign_o    <= 1'b0;
         illegal_o     <= 1'b0;
         target_o      <= 32'd0;
         link_o        <= 32'd0;
         taken_count_o <= '0;
      end else begin
         redirect_o <= do_redirect;
         misalign_o <= do_misalign;
         illegal_o  <= do_illegal;
         if (accept) target_o <= target_calc;
         if (accept && (is_jal_i || is_jalr_i)) link_o <= pc_i + 32'd4;
         if (do_redirect && (taken_count_o != {CNT_W{1'b1}}))
            taken_count_o <= taken_count_o + 1'b1;
      end
   end

endmodule

// File: doc/branch_resolve_rv32i.md
Name: branch_resolve_rv32i

Overview:
- EX-stage consumer of the RV32I comparator flags (eq/neq/lt/ge/ltu/geu).
- Selects the flag by funct3, resolves conditional branches, JAL and JALR, and computes the target address.
- Issues a registered one-cycle PC redirect to fetch, then squashes wrong-path EX instructions for FLUSH_CYCLES cycles.
- Static not-taken prediction: every taken control transfer redirects.

Parameters:
- FLUSH_CYCLES, 2, number of cycles wrong-path EX instructions are squashed after a redirect (1..15).
- CNT_W, 16, width of the saturating taken-redirect counter.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- stall_i  in  1  pipeline stall; freezes all state, no instruction accepted.
- ex_valid_i  in  1  EX holds a valid instruction.
- is_branch_i  in  1  conditional branch (B-type).
- is_jal_i  in  1  JAL.
- is_jalr_i  in  1  JALR.
- funct3_i  in  3  branch condition select.
- pc_i  in  32  PC of EX instruction.
- imm_i  in  32  sign-extended immediate.
- rs1_i  in  32  rs1 operand (JALR base).
- eq_i, neq_i, lt_i, ge_i, ltu_i, geu_i  in  1 each  comparator flags for rs1 vs rs2.
- redirect_o  out  1  one-cycle pulse: fetch must load target_o.
- target_o  out  32  registered resolved target.
- link_o  out  32  registered pc+4 of the last accepted JAL/JALR.
- flush_o  out  1  high while in FLUSH; the EX instruction is squashed.
- misalign_o  out  1  one-cycle pulse: taken target not 4-byte aligned.
- illegal_o  out  1  one-cycle pulse: branch with funct3 010/011.
- taken_count_o  out  CNT_W  saturating count of redirect_o pulses.

Behaviour:
- Reset, checked before any other condition: state=IDLE, flush counter=0, all outputs 0. Reset mid-FLUSH returns to IDLE on the same edge.
- Accept condition: ex_valid_i & !stall_i & state==IDLE. In FLUSH, ex_valid_i is ignored.
- Type priority when several flags are set: is_jal_i > is_jalr_i > is_branch_i. If none is set, accept has no effect.
- Conditional branch, funct3 to flag:
  - 000 -> eq_i, 001 -> neq_i
  - 100 -> lt_i, 101 -> ge_i
  - 110 -> ltu_i, 111 -> geu_i
  - 010/011 -> not taken; illegal_o=1 on next cycle.
- Target arithmetic, mod 2^32 with wrap-around and no overflow flag:
  - branch/JAL: pc_i+imm_i.
  - JALR: (rs1_i+imm_i) with bit0 cleared.
- Latency: decision is combinational in accept cycle N. At edge N+1:
  - target_o is latched for every accepted control transfer.
  - link_o = pc_i+4 for JAL/JALR only.
  - Pulse outputs are asserted for exactly cycle N+1.
- Taken path:
  - If target[1]==1: misalign_o=1, no redirect, no flush, count unchanged.
  - Otherwise: redirect_o=1, state->FLUSH, counter=FLUSH_CYCLES, taken_count_o+=1 (saturates at 2^CNT_W-1).
- Not-taken branch: no pulses; target_o still updates.
- FSM:
  - IDLE -> FLUSH on redirect.
  - FLUSH: flush_o=1.
  - If !stall_i, counter decrements; on counter 1 -> 0, the next state is IDLE.
  - stall_i holds the counter and keeps flush_o=1.
- Stall in IDLE: pulse outputs 0; target_o, link_o and the counter hold.
- Back-to-back: an instruction presented in the first IDLE cycle after FLUSH is accepted normally.

Test Plan:
- BEQ, pc=0x100, imm=0x20, eq_i=1 -> next cycle redirect_o=1, target_o=0x120. flush_o=1 for exactly 2 cycles, then 0. taken_count_o=1.
- BLTU, ltu_i=0, pc=0x200 -> no redirect_o, flush_o stays 0, target_o=0x200+imm, count unchanged.
- JALR, rs1=0x1003, imm=0, pc=0x40 -> target_o=0x1002, misalign_o=1, redirect_o=0, link_o=0x44, no flush.
- JAL, pc=0xFFFFFFF0, imm=0x20 -> target_o=0x00000010 (wrap-around), redirect_o=1, link_o=0xFFFFFFF4.
- Redirect, then ex_valid_i=1 with a taken branch during FLUSH, plus stall_i=1 for 3 cycles mid-flush -> second branch ignored. flush_o high for 2+3 cycles. rst=1 mid-flush -> flush_o=0 and all outputs 0 next cycle.
- funct3=010 branch -> illegal_o pulse, no redirect. Set is_jal_i and is_branch_i together -> JAL taken. Issue 2^CNT_W+1 redirects with CNT_W=4 -> taken_count_o saturates at 15.
